// File: rtl/mmio_accum_responder.sv
// MMIO responder with operand push FIFO and a 64-bit accumulate engine; read data is registered (1-cycle latency).
// No backpressure: pushes to a full FIFO without a same-cycle pop are dropped and set sticky ovf.
module mmio_accum_responder #(
    parameter int D_WIDTH    = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         mem_addr_in,
    input  logic [D_WIDTH-1:0] mem_data_in,
    input  logic               mem_we_in,
    output logic [D_WIDTH-1:0] mem_data_out,
    output logic               irq_done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] A_CTRL   = 8'h40;
    localparam logic [7:0] A_STATUS = 8'h41;
    localparam logic [7:0] A_PUSH   = 8'h42;
    localparam logic [7:0] A_RESULT = 8'h43;
    localparam logic [7:0] A_TARGET = 8'h44;

    logic [D_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          fifo_cnt;
    logic                 ovf;

    logic [1:0]           state;
    logic [D_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0] target;
    logic [CNT_WIDTH-1:0] remaining;

    logic [7:0]           word;
    logic                 sel;
    logic                 wr_en;
    logic                 ctrl_wr;
    logic                 start;
    logic                 clear;
    logic                 push_req;
    logic                 push_ok;
    logic                 pop;
    logic                 empty;
    logic                 full;
    logic [D_WIDTH-1:0]   head;
    logic [D_WIDTH-1:0]   rd_val;
    logic                 unused_addr_lsb;

    assign word            = mem_addr_in[9:2];
    assign sel             = |mem_addr_in[9:8];
    assign unused_addr_lsb = ^mem_addr_in[1:0];

    assign wr_en    = sel && mem_we_in;
    assign ctrl_wr  = wr_en && (word == A_CTRL);
    assign start    = ctrl_wr && mem_data_in[0];
    assign clear    = ctrl_wr && mem_data_in[1];
    assign push_req = wr_en && (word == A_PUSH);

    assign empty = (fifo_cnt == '0);
    assign full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign head  = fifo_mem[rd_ptr];

    // Clear wins over any pop that would otherwise happen on the same edge.
    assign pop     = (state == ST_RUN) && !empty && !clear;
    assign push_ok = push_req && !clear && (!full || pop);

    assign irq_done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= mem_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                fifo_cnt <= fifo_cnt + (AW+1)'(1);
            end else if (pop && !push_ok) begin
                fifo_cnt <= fifo_cnt - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            ovf <= 1'b0;
        end else if (push_req && !push_ok) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            target <= '0;
        end else if (wr_en && (word == A_TARGET)) begin
            target <= mem_data_in[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            state     <= ST_IDLE;
            acc       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        acc       <= '0;
                        remaining <= target;
                        state     <= (target == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        acc       <= acc + head;
                        remaining <= remaining - CNT_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (word)
            A_STATUS: begin
                rd_val[0]     = (state == ST_DONE);
                rd_val[1]     = (state == ST_RUN);
                rd_val[2]     = empty;
                rd_val[3]     = full;
                rd_val[4]     = ovf;
                rd_val[15:8]  = 8'(fifo_cnt);
                rd_val[31:16] = 16'(remaining);
            end
            A_RESULT: rd_val = acc;
            A_TARGET: rd_val[CNT_WIDTH-1:0] = target;
            default:  rd_val = '0;
        endcase
    end

    // Registered from current state, so a same-cycle write shows its old value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_data_out <= '0;
        end else begin
            mem_data_out <= sel ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_mmio_accum_responder.sv
// Directed bench for mmio_accum_responder: bus writes/reads through tasks, immediate-assert checks.
module tb_mmio_accum_responder;

    localparam logic [9:0] AD_CTRL   = 10'h100;
    localparam logic [9:0] AD_STATUS = 10'h104;
    localparam logic [9:0] AD_PUSH   = 10'h108;
    localparam logic [9:0] AD_RESULT = 10'h10C;
    localparam logic [9:0] AD_TARGET = 10'h110;

    logic        clk;
    logic        reset_n;
    logic [9:0]  mem_addr_in;
    logic [63:0] mem_data_in;
    logic        mem_we_in;
    logic [63:0] mem_data_out;
    logic        irq_done;

    int checks = 0;
    int errors = 0;

    mmio_accum_responder #(
        .D_WIDTH(64),
        .FIFO_DEPTH(8),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mem_addr_in(mem_addr_in),
        .mem_data_in(mem_data_in),
        .mem_we_in(mem_we_in),
        .mem_data_out(mem_data_out),
        .irq_done(irq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write is sampled on the following posedge.
    task automatic bus_write(input logic [9:0] a, input logic [63:0] d);
        mem_addr_in = a;
        mem_data_in = d;
        mem_we_in   = 1'b1;
        @(negedge clk);
        mem_we_in   = 1'b0;
        mem_addr_in = '0;
        mem_data_in = '0;
    endtask

    task automatic bus_read(input logic [9:0] a, output logic [63:0] d);
        mem_addr_in = a;
        mem_we_in   = 1'b0;
        @(negedge clk);
        d = mem_data_out;
        mem_addr_in = '0;
    endtask

    task automatic read_check(input string tag, input logic [9:0] a, input logic [63:0] exp);
        logic [63:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int n = 0;
        while (!irq_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n), 64'(exp_cycles));
    endtask

    initial begin
        reset_n     = 1'b0;
        mem_addr_in = '0;
        mem_data_in = '0;
        mem_we_in   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        check("reset_data_out", mem_data_out, 64'h0);
        check("reset_irq", 64'(irq_done), 64'h0);
        read_check("reset_status", AD_STATUS, 64'h4);

        // Basic accumulate of 1..4
        for (int i = 1; i <= 4; i++) bus_write(AD_PUSH, 64'(i));
        bus_write(AD_TARGET, 64'd4);
        bus_write(AD_CTRL, 64'h1);
        wait_done("basic_cycles", 4);
        check("basic_irq", 64'(irq_done), 64'h1);
        read_check("basic_result", AD_RESULT, 64'd10);
        read_check("basic_status", AD_STATUS, 64'h5);

        // Overflow: nine pushes into an idle eight-deep FIFO
        bus_write(AD_CTRL, 64'h2);
        check("clear_irq", 64'(irq_done), 64'h0);
        for (int i = 1; i <= 9; i++) bus_write(AD_PUSH, 64'(i));
        read_check("ovf_status", AD_STATUS, 64'h818);
        bus_write(AD_TARGET, 64'd8);
        bus_write(AD_CTRL, 64'h1);
        wait_done("ovf_cycles", 8);
        read_check("ovf_result", AD_RESULT, 64'd36);
        read_check("ovf_status_done", AD_STATUS, 64'h15);

        // Stalls: start with empty FIFO, pushes arrive with gaps
        bus_write(AD_CTRL, 64'h2);
        bus_write(AD_TARGET, 64'd3);
        bus_write(AD_CTRL, 64'h1);
        read_check("stall_status0", AD_STATUS, 64'h0003_0006);
        repeat (3) @(negedge clk);
        bus_write(AD_PUSH, 64'd5);
        read_check("stall_status1", AD_STATUS, 64'h0003_0102);
        repeat (2) @(negedge clk);
        bus_write(AD_PUSH, 64'd5);
        repeat (3) @(negedge clk);
        read_check("stall_status2", AD_STATUS, 64'h0001_0006);
        check("stall_irq_low", 64'(irq_done), 64'h0);
        bus_write(AD_PUSH, 64'd5);
        wait_done("stall_cycles", 1);
        read_check("stall_result", AD_RESULT, 64'd15);

        // Push into a full FIFO on a pop cycle is accepted
        bus_write(AD_CTRL, 64'h2);
        for (int i = 1; i <= 8; i++) bus_write(AD_PUSH, 64'(i));
        bus_write(AD_TARGET, 64'd9);
        bus_write(AD_CTRL, 64'h1);
        bus_write(AD_PUSH, 64'd100);
        read_check("fullpop_status", AD_STATUS, 64'h0008_080A);
        wait_done("fullpop_cycles", 7);
        read_check("fullpop_result", AD_RESULT, 64'd136);
        read_check("fullpop_status_done", AD_STATUS, 64'h5);

        // Clear+start mid-RUN with overflowed FIFO
        bus_write(AD_CTRL, 64'h2);
        for (int i = 0; i < 9; i++) bus_write(AD_PUSH, 64'd7);
        bus_write(AD_TARGET, 64'd5);
        bus_write(AD_CTRL, 64'h1);
        @(negedge clk);
        bus_write(AD_CTRL, 64'h3);
        read_check("abort_status", AD_STATUS, 64'h4);
        read_check("abort_result", AD_RESULT, 64'h0);
        check("abort_irq", 64'(irq_done), 64'h0);

        // TARGET=0 finishes immediately
        bus_write(AD_TARGET, 64'd0);
        bus_write(AD_CTRL, 64'h1);
        check("zero_irq", 64'(irq_done), 64'h1);
        read_check("zero_result", AD_RESULT, 64'h0);
        read_check("zero_status", AD_STATUS, 64'h5);

        // Out-of-region access
        bus_write(10'h0FC, 64'hFFFF_FFFF_FFFF_FFFF);
        check("oor_write_data", mem_data_out, 64'h0);
        read_check("oor_read", 10'h0FC, 64'h0);
        read_check("oor_status", AD_STATUS, 64'h5);
        read_check("oor_target", AD_TARGET, 64'h0);

        // Same-cycle write returns pre-update value; TARGET is truncated to 16 bits
        bus_write(AD_TARGET, 64'hABCD_1234);
        check("target_preupdate", mem_data_out, 64'h0);
        read_check("target_read", AD_TARGET, 64'h1234);

        // Reset in the middle of a run
        bus_write(AD_PUSH, 64'd3);
        bus_write(AD_PUSH, 64'd4);
        bus_write(AD_TARGET, 64'd4);
        bus_write(AD_CTRL, 64'h1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_data_out", mem_data_out, 64'h0);
        check("rst_irq", 64'(irq_done), 64'h0);
        read_check("rst_status", AD_STATUS, 64'h4);
        read_check("rst_result", AD_RESULT, 64'h0);
        read_check("rst_target", AD_TARGET, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
